// File: rtl/vga_scan_out.sv
// vga_scan_out: 640x480@60 VGA scan-out for the 9-bit (RGB 3:3:3) video memory.
// Stage 0 runs the raster counters and the linear read address, stage 1 waits
// out the one-clock memory read latency, stage 2 registers the DAC pins.
// Optional feature macro: TEST_PATTERN_EN adds tp_sel, which replaces the
// memory colour with eight 80-pixel vertical colour bars.
module vga_scan_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
`ifdef TEST_PATTERN_EN
    input  logic        tp_sel,
`endif
    output logic [18:0] raddr,
    input  logic [8:0]  rdata,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vblank,
    output logic        vblank_start
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(HT - 1);
    localparam logic [9:0] V_LAST = 10'(VT - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Replicate a 3-bit colour field across 8 bits so 7 maps to 0xFF.
    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    logic [9:0]  hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic [18:0] addr_q, addr_d;
    logic        active0, hs0, vs0, vb0;
    logic        active1_q, active1_d;
    logic        hs1_q, hs1_d;
    logic        vs1_q, vs1_d;
    logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_n_q, blank_n_d;
    logic        vblank_q, vblank_d;
    logic        vblank_start_q, vblank_start_d;

`ifdef TEST_PATTERN_EN
    logic [9:0]  hcnt1_q, hcnt1_d;
    logic [2:0]  bar_idx;
    assign bar_idx = 3'(hcnt1_q / 10'd80);
`endif

    // Stage-0 raster decode: visible region, sync pulses and vertical blank.
    always_comb begin
        active0 = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hs0     = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
        vs0     = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
        vb0     = (vcnt_q >= V_ACT);
    end

    // Raster counters and read address; the address only advances on visible
    // pixels so it needs no multiply and parks on the next line's first pixel.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        addr_d = addr_q;
        if (!en) begin
            hcnt_d = '0;
            vcnt_d = '0;
            addr_d = '0;
        end else begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
            if ((hcnt_q == H_LAST) && (vcnt_q == V_LAST)) begin
                addr_d = '0;
            end else if (active0) begin
                addr_d = addr_q + 19'd1;
            end
        end
    end

    // Stage 1/2 and blank status; en low flushes everything to idle values.
    always_comb begin
        active1_d      = en & active0;
        hs1_d          = !en | hs0;
        vs1_d          = !en | vs0;
        r_d            = '0;
        g_d            = '0;
        b_d            = '0;
        if (en && active1_q) begin
            r_d = expand3(rdata[8:6]);
            g_d = expand3(rdata[5:3]);
            b_d = expand3(rdata[2:0]);
`ifdef TEST_PATTERN_EN
            // Bars run white, yellow, cyan, green, magenta, red, blue, black.
            if (tp_sel) begin
                r_d = {8{~bar_idx[1]}};
                g_d = {8{~bar_idx[2]}};
                b_d = {8{~bar_idx[0]}};
            end
`endif
        end
        hs_d           = !en | hs1_q;
        vs_d           = !en | vs1_q;
        blank_n_d      = en & active1_q;
        vblank_d       = en & vb0;
        vblank_start_d = en & vb0 & !vblank_q;
`ifdef TEST_PATTERN_EN
        hcnt1_d        = en ? hcnt_q : 10'd0;
`endif
    end

    // All pipeline state, cleared asynchronously to the idle raster.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q         <= '0;
            vcnt_q         <= '0;
            addr_q         <= '0;
            active1_q      <= 1'b0;
            hs1_q          <= 1'b1;
            vs1_q          <= 1'b1;
            r_q            <= '0;
            g_q            <= '0;
            b_q            <= '0;
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
            blank_n_q      <= 1'b0;
            vblank_q       <= 1'b0;
            vblank_start_q <= 1'b0;
`ifdef TEST_PATTERN_EN
            hcnt1_q        <= '0;
`endif
        end else begin
            hcnt_q         <= hcnt_d;
            vcnt_q         <= vcnt_d;
            addr_q         <= addr_d;
            active1_q      <= active1_d;
            hs1_q          <= hs1_d;
            vs1_q          <= vs1_d;
            r_q            <= r_d;
            g_q            <= g_d;
            b_q            <= b_d;
            hs_q           <= hs_d;
            vs_q           <= vs_d;
            blank_n_q      <= blank_n_d;
            vblank_q       <= vblank_d;
            vblank_start_q <= vblank_start_d;
`ifdef TEST_PATTERN_EN
            hcnt1_q        <= hcnt1_d;
`endif
        end
    end

    assign raddr        = addr_q;
    assign vga_r        = r_q;
    assign vga_g        = g_q;
    assign vga_b        = b_q;
    assign vga_hs       = hs_q;
    assign vga_vs       = vs_q;
    assign vga_blank_n  = blank_n_q;
    assign vblank       = vblank_q;
    assign vblank_start = vblank_start_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Directed bench for vga_scan_out. One instance uses the real 640x480 timing
// for line-level checks; a second, scaled instance (25 clk x 11 lines) keeps
// frame-level checks short: 16x6 visible, hsync x 18..21, vsync lines 7..8.
module tb_vga_scan_out;

    logic        clk;
    logic        rstN;
    logic        enIn;
    logic        forceEn;
    logic [8:0]  forceVal;
`ifdef TEST_PATTERN_EN
    logic        tpSel;
`endif

    logic [18:0] raddrFull, raddrSmall;
    logic [8:0]  rdataFull, rdataSmall;
    logic [7:0]  rFull, gFull, bFull, rSmall, gSmall, bSmall;
    logic        hsFull, vsFull, blankFull, vbFull, vbsFull;
    logic        hsSmall, vsSmall, blankSmall, vbSmall, vbsSmall;

    int checkCount;
    int passCount;
    int t;
    int n;
    logic prevVs;
    logic found;

    vga_scan_out dutFull (
        .clk(clk), .rst_n(rstN), .en(enIn),
`ifdef TEST_PATTERN_EN
        .tp_sel(tpSel),
`endif
        .raddr(raddrFull), .rdata(rdataFull),
        .vga_r(rFull), .vga_g(gFull), .vga_b(bFull),
        .vga_hs(hsFull), .vga_vs(vsFull), .vga_blank_n(blankFull),
        .vblank(vbFull), .vblank_start(vbsFull)
    );

    vga_scan_out #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dutSmall (
        .clk(clk), .rst_n(rstN), .en(enIn),
`ifdef TEST_PATTERN_EN
        .tp_sel(tpSel),
`endif
        .raddr(raddrSmall), .rdata(rdataSmall),
        .vga_r(rSmall), .vga_g(gSmall), .vga_b(bSmall),
        .vga_hs(hsSmall), .vga_vs(vsSmall), .vga_blank_n(blankSmall),
        .vblank(vbSmall), .vblank_start(vbsSmall)
    );

    // 25 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Video memory models: one-clock read latency, data = low 9 address bits,
    // with an override so specific colour codes can be injected.
    always @(posedge clk) begin
        rdataFull  <= forceEn ? forceVal : raddrFull[8:0];
        rdataSmall <= raddrSmall[8:0];
    end

    // Drive reset and enable together.
    task automatic applyStimulus(input logic rstVal, input logic enVal);
        rstN = rstVal;
        enIn = enVal;
    endtask

    // Advance n rising edges and settle on the following falling edge.
    task automatic stepCycles(input int cnt);
        repeat (cnt) @(posedge clk);
        @(negedge clk);
        t += cnt;
    endtask

    // Count one comparison and report any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)",
                      tag, observed, expected, t);
    endtask

    // Directed sequence.
    initial begin
        checkCount = 0;
        passCount  = 0;
        t          = 0;
        forceEn    = 1'b0;
        forceVal   = '0;
`ifdef TEST_PATTERN_EN
        tpSel      = 1'b0;
`endif
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);

        checkOutput("rstRaddr", raddrFull, 0);
        checkOutput("rstSync", {hsFull, vsFull}, 2'b11);
        checkOutput("rstBlank", blankFull, 0);
        checkOutput("rstRgb", {rFull, gFull, bFull}, 0);
        checkOutput("rstVblank", {vbFull, vbsFull}, 2'b00);

        applyStimulus(1'b1, 1'b0);
        stepCycles(3);
        checkOutput("idleBlank", blankFull, 0);
        checkOutput("idleRaddr", raddrFull, 0);
        checkOutput("idleHs", hsFull, 1);

        // Full-size timing: t counts edges since en rose.
        applyStimulus(1'b1, 1'b1);
        t = 0;
        checkOutput("firstRaddr", raddrFull, 0);
        stepCycles(2);
        checkOutput("pix0Blank", blankFull, 1);
        checkOutput("pix0Rgb", {rFull, gFull, bFull}, 0);
        checkOutput("pix0Raddr", raddrFull, 2);
        stepCycles(3);
        checkOutput("pix3Rgb", {rFull, gFull, bFull}, 24'h00006D);

        stepCycles(4);
        forceEn  = 1'b1;
        forceVal = 9'h1C0;
        stepCycles(1);
        forceVal = 9'h088;
        stepCycles(1);
        checkOutput("red1C0", {rFull, gFull, bFull}, 24'hFF0000);
        forceEn = 1'b0;
        stepCycles(1);
        checkOutput("trans088", {rFull, gFull, bFull}, 24'h492400);

        stepCycles(641 - t);
        checkOutput("pix639Blank", blankFull, 1);
        checkOutput("pix639Red", rFull, 8'h24);
        stepCycles(1);
        checkOutput("hBlank", blankFull, 0);
        checkOutput("hBlankRgb", {rFull, gFull, bFull}, 0);
        stepCycles(650 - t);
        checkOutput("parkAddr", raddrFull, 640);
        stepCycles(657 - t);
        checkOutput("hsBefore", hsFull, 1);
        stepCycles(1);
        checkOutput("hsFall", hsFull, 0);
        n = 0;
        for (int i = 0; i < 800; i++) begin
            if (!hsFull) n++;
            stepCycles(1);
        end
        checkOutput("hsWidth", n, 96);
        stepCycles(1600 - t);
        checkOutput("line2Addr", raddrFull, 1280);
        checkOutput("noVblank", vbFull, 0);

        // Scaled instance: restart from idle.
        applyStimulus(1'b1, 1'b0);
        stepCycles(1);
        checkOutput("enLowRaddr", raddrSmall, 0);
        checkOutput("enLowSync", {hsSmall, vsSmall, blankSmall}, 3'b110);
        applyStimulus(1'b1, 1'b1);
        t = 0;

        stepCycles(140);
        checkOutput("lastAddr", raddrSmall, 95);
        stepCycles(2);
        checkOutput("lastBlank", blankSmall, 1);
        checkOutput("lastRgb", {rSmall, gSmall, bSmall}, 24'h246DFF);
        stepCycles(1);
        checkOutput("vAreaEnd", blankSmall, 0);
        stepCycles(150 - t);
        checkOutput("vbPre", {vbSmall, vbsSmall}, 2'b00);
        stepCycles(1);
        checkOutput("vbRise", {vbSmall, vbsSmall}, 2'b11);
        stepCycles(1);
        checkOutput("vbsPulse", {vbSmall, vbsSmall}, 2'b10);
        stepCycles(176 - t);
        checkOutput("vsBefore", vsSmall, 1);
        stepCycles(1);
        checkOutput("vsFall", vsSmall, 0);

        prevVs = vsSmall;
        n      = 0;
        found  = 1'b0;
        while (!found && n < 1000) begin
            stepCycles(1);
            n++;
            if (prevVs && !vsSmall) found = 1'b1;
            prevVs = vsSmall;
        end
        checkOutput("framePeriod", n, 275);

        stepCycles(549 - t);
        checkOutput("frameEndAddr", raddrSmall, 96);
        stepCycles(1);
        checkOutput("wrapAddr", raddrSmall, 0);
        checkOutput("wrapVb", vbSmall, 1);
        stepCycles(1);
        checkOutput("vbFall", vbSmall, 0);

        // Drop en at hcnt=5, vcnt=3 for five clocks.
        stepCycles(630 - t);
        checkOutput("midAddr", raddrSmall, 53);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            stepCycles(1);
            checkOutput("holdAddr", raddrSmall, 0);
            checkOutput("holdPins", {hsSmall, vsSmall, blankSmall}, 3'b110);
            checkOutput("holdRgb", {rSmall, gSmall, bSmall}, 0);
        end
        applyStimulus(1'b1, 1'b1);
        t = 0;
        checkOutput("restartAddr", raddrSmall, 0);
        stepCycles(1);
        checkOutput("restartBlank1", blankSmall, 0);
        stepCycles(1);
        checkOutput("restartBlank2", blankSmall, 1);
        checkOutput("restartRgb", {rSmall, gSmall, bSmall}, 0);

        // Asynchronous reset in the middle of a visible line.
        stepCycles(8);
        checkOutput("preRstBlank", blankSmall, 1);
        rstN = 1'b0;
        #1;
        checkOutput("asyncPins", {hsSmall, vsSmall, blankSmall}, 3'b110);
        checkOutput("asyncAddr", raddrSmall, 0);
        @(negedge clk);
        rstN = 1'b1;
        t = 0;
        n = 0;
        while (vsSmall && n < 2000) begin
            stepCycles(1);
            n++;
        end
        checkOutput("firstVsync", n, 177);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vga_scan_out.md
Name: vga_scan_out

Overview:
- Read-side counterpart of the bitmap placer. The placer writes 9-bit pixels into the 640x480 video memory; this block reads them back out.
- Generates 640x480@60 VGA timing and issues linear read addresses to the video memory's read port.
- Takes the 1-cycle-latency read data, expands each 3-bit colour field to 8 bits, and drives the DAC pins with aligned sync and blank.
- Exports vertical-blank status so writers can update memory without tearing.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in clocks
- H_SYNC, 96, hsync pulse width, in clocks
- H_BP, 48, horizontal back porch, in clocks
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vsync width, in lines
- V_BP, 33, vertical back porch, in lines

Ports:
- clk  in  1  25 MHz pixel clock
- rst_n  in  1  reset
- en  in  1  scan enable; low holds scanner idle
- raddr  out  19  video memory read address
- rdata  in  9  video memory read data, valid 1 clk after raddr is sampled
- vga_r  out  8  red
- vga_g  out  8  green
- vga_b  out  8  blue
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- vga_blank_n  out  1  low outside the active region
- vblank  out  1  high while the scan line is >= V_ACTIVE
- vblank_start  out  1  one-clk pulse on entry to vblank

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - hcnt=0, vcnt=0, addr_cnt=0, raddr=0.
  - vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0.
  - vblank=0, vblank_start=0.
- Stage 0 (counters):
  - hcnt runs 0..HT-1, with HT = sum of the H parameters = 800.
  - vcnt increments when hcnt wraps, and runs 0..VT-1, with VT = 525.
  - active0 = (hcnt<H_ACTIVE) && (vcnt<V_ACTIVE).
  - hs0 is low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [656,752).
  - vs0 is low for vcnt in [490,492).
- Address generation:
  - No multiplier. addr_cnt increments on each active0 clk and is reset to 0 when hcnt=HT-1 and vcnt=VT-1.
  - raddr = addr_cnt (registered). During blanking it holds the address of the next active pixel.
  - The last active pixel of a frame addresses 307199 (0x4AFFF).
- Stage 1: active0, hs0 and vs0 are registered to align with rdata.
- Stage 2 (output register), loaded every clk:
  - If active1: vga_r={rdata[8:6],rdata[8:6],rdata[8:7]}, vga_g likewise from [5:3], vga_b likewise from [2:0]. Otherwise all colours are 0.
  - vga_blank_n=active1, vga_hs=hs1, vga_vs=vs1.
- Latency: pin outputs lag the stage-0 counters by exactly 2 clk. Pixel (x,y) appears on the pins 2 clk after hcnt=x, vcnt=y.
- vblank: registered from stage 0, asserted the clk after vcnt becomes >=480, and cleared the clk after vcnt wraps to 0.
- vblank_start: high for exactly one clk, coincident with vblank rising.
- en low, including mid-frame: next clk, counters, addr_cnt and the pipeline return to their reset values. Outputs read as reset values from the following clk.
- en rising: scanning starts at hcnt=0, vcnt=0. The first pixel, address 0, reaches the pins 2 clk later.
- No handshake with the writer; memory is dual-ported. The transparent code 0x088 has no meaning on readout and is displayed as-is.

Optional Feature:
- Macro: TEST_PATTERN_EN.
- Defined: adds input tp_sel (1 bit). When tp_sel=1, the stage-2 colour comes from eight vertical bars, each 80 px wide. Bar index = hcnt_delayed[9:...]/80, ordered white, yellow, cyan, green, magenta, red, blue, black. Full 0xFF/0x00 channels; rdata is ignored. Timing and latency are unchanged.
- Undefined: no tp_sel port; colour always comes from rdata.

Test Plan:
- Reset then en=1, count clks between vga_vs falling edges -> exactly 420000 (800x525). vga_hs low for 96 clk per 800-clk line.
- Memory model returns rdata = raddr[8:0]; check pixel (0,0) -> raddr=0, and 2 clk later vga_blank_n=1 with r=g=b=0. Check pixel (639,479) -> raddr=307199.
- rdata=9'h1C0 at an active pixel -> vga_r=8'hFF, vga_g=0, vga_b=0. rdata=9'h088 -> r=8'h49, g=8'h24, b=0.
- Observe line 480 start -> vblank rises, vblank_start high exactly 1 clk. vblank falls at the vcnt 524->0 wrap, and raddr=0 then.
- Drop en at hcnt=300, vcnt=100 for 5 clk, then restore -> outputs at reset values during the idle time. After en returns, raddr restarts at 0 and the first active pixel appears 2 clk later.
- Assert rst_n low mid-line -> outputs immediately at reset values (hs=vs=1, blank_n=0). After release, first vsync occurs 490 lines later.
